// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write port bundle for imem_loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory programmer: count byte, big-endian words, one write per word.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] widx;
    logic [1:0]  bidx;
    logic [31:0] asm_q;
    logic        acc;
    logic        n_bad;
    logic        last_word;
    logic [31:0] word_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign acc       = bus.in_valid && bus.in_ready;
    assign n_bad     = (bus.in_data == 8'd0) ||
                       (32'(bus.in_data) > 32'(DEPTH));
    assign last_word = (bidx == 2'd3) && (widx == cnt - CW'(1));
    assign word_n    = {asm_q[23:0], bus.in_data};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_n      = state;
        busy         = 1'b1;
        done         = 1'b0;
        bus.in_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_n = S_COUNT;
            end
            S_COUNT: begin
                bus.in_ready = 1'b1;
                if (acc) state_n = n_bad ? S_DONE : S_DATA;
            end
            S_DATA: begin
                bus.in_ready = 1'b1;
                if (acc && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_n = S_CHECK;
`else
                    state_n = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                bus.in_ready = 1'b1;
                if (acc) state_n = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: counters, word assembly, registered write port, error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            widx      <= '0;
            bidx      <= '0;
            asm_q     <= '0;
            err       <= 1'b0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            bus.we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        widx  <= '0;
                        bidx  <= '0;
                        asm_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (acc) begin
                        if (n_bad) err <= 1'b1;
                        else       cnt <= CW'(bus.in_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= bus.in_data;
`endif
                    end
                end
                S_DATA: begin
                    if (acc) begin
                        asm_q <= word_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum   <= sum + bus.in_data;
`endif
                        if (bidx == 2'd3) begin
                            bus.we    <= 1'b1;
                            bus.waddr <= ADDR_W'({widx, 2'b00});
                            bus.wdata <= word_n;
                            widx      <= widx + CW'(1);
                            bidx      <= '0;
                        end else begin
                            bidx <= bidx + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (acc && ((sum + bus.in_data) != 8'd0)) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level reference model.
// Expected writes come from decoding the byte image, not from the RTL.
module tb_imem_loader;
    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    imem_loader_if #(.ADDR_W(32)) bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    wr_t         cur;
    int          we_cnt = 0;
    logic [31:0] last_addr = '0;
    logic        acc_q = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: decode the image into the writes and final err it implies.
    task automatic model(input logic [7:0] s[$], output int used,
                         output bit e);
        int n;
        wr_t w;
        logic [7:0] sm;
        n = int'(s[0]);
        e = 1'b0;
        used = 1;
        if (n == 0 || n > DEPTH) begin
            e = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w.addr = 32'(4 * k);
            w.data = {s[1+4*k], s[2+4*k], s[3+4*k], s[4+4*k]};
            exp_q.push_back(w);
        end
        used = 1 + 4 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        used++;
        sm = 8'd0;
        for (int i = 0; i < used; i++) sm = sm + s[i];
        e = (sm != 8'd0);
`else
        sm = 8'd0;
`endif
    endtask

    task automatic make_image(input int n, input int seed,
                              output logic [7:0] s[$]);
        logic [7:0] sm;
        logic [7:0] b;
        s.delete();
        s.push_back(8'(n));
        sm = 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'(i * 7 + seed);
            s.push_back(b);
            sm = sm + b;
        end
        s.push_back(8'd0 - sm);
    endtask

    always @(posedge clk) acc_q <= bus.in_valid && bus.in_ready;

    // Compare every write strobe against the model's write list.
    always @(negedge clk) begin
        if (!rst && bus.we) begin
            we_cnt++;
            last_addr = bus.waddr;
            check("we_after_accept", 32'(acc_q), 32'd1);
            check("we_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("waddr", bus.waddr, cur.addr);
                check("wdata", bus.wdata, cur.data);
            end
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("busy_in_gap", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_load(input logic [7:0] s[$], input int gap,
                            input int poke);
        int used;
        bit e;
        model(s, used, e);
        do_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(bus.in_ready), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < used; i++) begin
            send(s[i], (i == used - 1) ? 0 : gap);
            if (i == poke) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                check("busy_start_ignored", 32'(busy), 32'd1);
                check("ready_start_ignored", 32'(bus.in_ready), 32'd1);
                check("err_start_ignored", 32'(err), 32'd0);
            end
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_low", 32'(done), 32'd0);
        check("busy_low", 32'(busy), 32'd0);
        check("ready_idle", 32'(bus.in_ready), 32'd0);
        check("err_final", 32'(err), 32'(e));
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s1[$];
        logic [7:0] s2[$];
        logic [7:0] sb[$];
        logic [7:0] img[$];
        int used;
        bit e;

        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_waddr", bus.waddr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        rst = 1'b0;

        s1 = '{8'h02, 8'h8C, 8'h08, 8'h00, 8'h00,
               8'h8C, 8'h09, 8'h00, 8'h04, 8'hD1};
        s2 = s1;
        s2[9] = 8'hD2;

        model(s1, used, e);
        check("pin_addr0", exp_q[0].addr, 32'h0);
        check("pin_data0", exp_q[0].data, 32'h8C080000);
        check("pin_addr1", exp_q[1].addr, 32'h4);
        check("pin_data1", exp_q[1].data, 32'h8C090004);
        check("pin_err_d1", 32'(e), 32'd0);
        exp_q.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("pin_used", 32'(used), 32'd10);
        model(s2, used, e);
        check("pin_err_d2", 32'(e), 32'd1);
        exp_q.delete();
`else
        check("pin_used", 32'(used), 32'd9);
`endif

        run_load(s1, 0, -1);
        run_load(s2, 0, -1);
        run_load(s1, 0, -1);

        sb = '{8'h00};
        run_load(sb, 0, -1);
        check("err_count0", 32'(err), 32'd1);
        sb = '{8'h41};
        run_load(sb, 0, -1);
        check("err_count41", 32'(err), 32'd1);

        make_image(DEPTH, 3, img);
        we_cnt = 0;
        run_load(img, 1, -1);
        check("full_we_count", 32'(we_cnt), 32'(DEPTH));
        check("full_last_addr", last_addr, 32'hFC);

        make_image(3, 11, img);
        model(img, used, e);
        do_start();
        for (int i = 0; i < 6; i++) send(img[i], 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_we", 32'(bus.we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_waddr", bus.waddr, 32'd0);
        check("midrst_wdata", bus.wdata, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        make_image(3, 40, img);
        we_cnt = 0;
        run_load(img, 0, -1);
        check("reload_we_count", 32'(we_cnt), 32'd3);

        make_image(2, 90, img);
        run_load(img, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
